fetch_refill_engine: RTL and testbench

//  Fetch-stage result driver and I-cache miss handler. Accepts one fetch request (PC + prediction) and

---
 rtl/fetch_refill_engine.sv | 194 +++++++++++++++++++
 tb/tb_fetch_refill_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_refill_engine.sv
// Fetch-stage result driver: returns the requested instruction from the hit line,
// or refills the line over an AXI INCR burst, optionally forwarding the target word early.
module fetch_refill_engine #(
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 8,
   parameter int WAYS       = 8,
   parameter bit EARLY_FWD  = 1'b1,
   localparam int OFF_W     = $clog2(LINE_WORDS * 4),
   localparam int IDX_W     = $clog2(SETS),
   localparam int TAG_W     = 32 - IDX_W - OFF_W,
   localparam int WAY_W     = $clog2(WAYS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_pre_i,
   output logic                    ready_pre_o,
   input  logic [31:0]             araddr_i,
   input  logic                    hit_i,
   input  logic [32*LINE_WORDS-1:0] hit_line_i,
   input  logic                    pvalid_i,
   input  logic                    ptaken_i,
   input  logic [31:0]             ptarget_i,
   output logic                    valid_post_o,
   input  logic                    ready_post_i,
   output logic [31:0]             pc_o,
   output logic [31:0]             inst_o,
   output logic                    fault_o,
   output logic                    pvalid_o,
   output logic                    ptaken_o,
   output logic [31:0]             ptarget_o,
   input  logic                    hold_i,
   input  logic                    is_csr_i,
   input  logic                    commit_csr_i,
   input  logic                    flush_i,
   output logic                    wen_o,
   output logic [IDX_W-1:0]        windex_o,
   output logic [WAY_W-1:0]        wway_o,
   output logic [TAG_W-1:0]        wtag_o,
   output logic [32*LINE_WORDS-1:0] wdata_o,
   output logic                    io_master_arvalid,
   input  logic                    io_master_arready,
   output logic [31:0]             io_master_araddr,
   output logic [3:0]              io_master_arid,
   output logic [7:0]              io_master_arlen,
   output logic [2:0]              io_master_arsize,
   output logic [1:0]              io_master_arburst,
   input  logic                    io_master_rvalid,
   output logic                    io_master_rready,
   input  logic [31:0]             io_master_rdata,
   input  logic [1:0]              io_master_rresp,
   input  logic                    io_master_rlast,
   input  logic [3:0]              io_master_rid,
   output logic [2:0]              state_o
);

   localparam int WI_W  = OFF_W - 2;
   localparam int CNT_W = WI_W + 1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      AR       = 3'd1,
      R        = 3'd2,
      LWR      = 3'd3,
      HIT_OUT  = 3'd4,
      MISS_OUT = 3'd5,
      CSR_WAIT = 3'd6,
      DRAIN    = 3'd7
   } state_e;

   state_e            state_q;
   logic [31:0]       pc_q;
   logic              pvalid_q, ptaken_q;
   logic [31:0]       ptarget_q;
   logic [31:0]       buf_q [LINE_WORDS];
   logic [CNT_W-1:0]  cnt_q;
   logic              err_q, delivered_q, drop_q, csr_q;
   logic [15:0]       lfsr_q;

   logic [WI_W-1:0]   word_idx;
   logic              fwd_ok, post_hs, fwd_hs;
   logic [15:0]       lfsr_next;
   logic              unused_rid;

   assign word_idx  = pc_q[OFF_W-1:2];
   // Early forward only once the target beat is already stored, so inst_o is a register read.
   assign fwd_ok    = EARLY_FWD && (state_q == R) && !delivered_q && ({1'b0, word_idx} < cnt_q);
   assign valid_post_o = ((state_q == HIT_OUT) || (state_q == MISS_OUT) || fwd_ok) && !hold_i && !flush_i;
   assign post_hs   = valid_post_o && ready_post_i;
   assign fwd_hs    = post_hs && (state_q == R);
   assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
   assign unused_rid = ^io_master_rid;

   assign ready_pre_o       = (state_q == IDLE);
   assign io_master_arvalid = (state_q == AR);
   assign io_master_araddr  = {pc_q[31:OFF_W], {OFF_W{1'b0}}};
   assign io_master_arid    = 4'd0;
   assign io_master_arlen   = 8'(LINE_WORDS - 1);
   assign io_master_arsize  = 3'b010;
   assign io_master_arburst = 2'b01;
   assign io_master_rready  = (state_q == R) || (state_q == DRAIN);

   assign wen_o    = (state_q == LWR) && !err_q;
   assign windex_o = pc_q[OFF_W+IDX_W-1:OFF_W];
   assign wtag_o   = pc_q[31:OFF_W+IDX_W];
   assign wway_o   = lfsr_q[WAY_W-1:0];

   assign pc_o      = pc_q;
   assign inst_o    = buf_q[word_idx];
   assign fault_o   = err_q;
   assign pvalid_o  = pvalid_q;
   assign ptaken_o  = ptaken_q;
   assign ptarget_o = ptarget_q;
   assign state_o   = state_q;

   always_comb begin
      wdata_o = '0;
      for (int i = 0; i < LINE_WORDS; i++) wdata_o[32*i +: 32] = buf_q[i];
   end

   // NOTE: state uses non-blocking assignments so every branch sees the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         pvalid_q    <= 1'b0;
         ptaken_q    <= 1'b0;
         ptarget_q   <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         delivered_q <= 1'b0;
         drop_q      <= 1'b0;
         csr_q       <= 1'b0;
         lfsr_q      <= 16'hACE1;
         // NOTE: the line buffer is small and drives wdata_o, so it is reset to keep outputs defined.
         for (int i = 0; i < LINE_WORDS; i++) buf_q[i] <= '0;
      end else begin
         case (state_q)
            IDLE: if (valid_pre_i) begin
               pc_q        <= araddr_i;
               pvalid_q    <= pvalid_i;
               ptaken_q    <= ptaken_i;
               ptarget_q   <= ptarget_i;
               err_q       <= 1'b0;
               delivered_q <= 1'b0;
               drop_q      <= 1'b0;
               csr_q       <= 1'b0;
               cnt_q       <= '0;
               for (int i = 0; i < LINE_WORDS; i++) buf_q[i] <= hit_line_i[32*i +: 32];
               state_q     <= hit_i ? HIT_OUT : AR;
            end
            AR: begin
               if (flush_i) drop_q <= 1'b1;
               if (io_master_arready) begin
                  lfsr_q  <= lfsr_next;
                  state_q <= (drop_q || flush_i) ? DRAIN : R;
               end
            end
            R, DRAIN: begin
               if (fwd_hs) begin
                  delivered_q <= 1'b1;
                  csr_q       <= is_csr_i;
               end
               if (state_q == R && flush_i && !delivered_q) begin
                  drop_q  <= 1'b1;
                  state_q <= DRAIN;
               end
               if (io_master_rvalid) begin
                  if (cnt_q < CNT_W'(LINE_WORDS)) begin
                     buf_q[cnt_q[WI_W-1:0]] <= io_master_rdata;
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
                  if (io_master_rresp != 2'b00) err_q <= 1'b1;
                  if (io_master_rlast) begin
                     cnt_q   <= '0;
                     state_q <= LWR;
                  end
               end
            end
            LWR: begin
               if (drop_q)           state_q <= IDLE;
               else if (delivered_q) state_q <= csr_q ? CSR_WAIT : IDLE;
               else                  state_q <= MISS_OUT;
            end
            HIT_OUT, MISS_OUT: begin
               if (flush_i)      state_q <= IDLE;
               else if (post_hs) state_q <= is_csr_i ? CSR_WAIT : IDLE;
            end
            CSR_WAIT: if (commit_csr_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_refill_engine.sv
// Directed bench for fetch_refill_engine: hit path, early-forward refill, flush drain,
// bus error, CSR wait and LFSR victim selection.
module tb_fetch_refill_engine;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid_pre, ready_pre, hit, pvalid, ptaken, valid_post, ready_post;
   logic [31:0]   araddr, ptarget, pc_o, inst_o, ptarget_o;
   logic [32*LW-1:0] hit_line, wdata;
   logic          fault, pvalid_o, ptaken_o, hold, is_csr, commit_csr, flush, wen;
   logic [2:0]    windex, wway, state;
   logic [24:0]   wtag;
   logic          arvalid, arready, rvalid, rready, rlast;
   logic [31:0]   ar_addr, rdata;
   logic [3:0]    arid, rid;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst, rresp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_refill_engine #(.LINE_WORDS(4), .SETS(8), .WAYS(8), .EARLY_FWD(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .valid_pre_i(valid_pre), .ready_pre_o(ready_pre), .araddr_i(araddr), .hit_i(hit),
      .hit_line_i(hit_line), .pvalid_i(pvalid), .ptaken_i(ptaken), .ptarget_i(ptarget),
      .valid_post_o(valid_post), .ready_post_i(ready_post), .pc_o(pc_o), .inst_o(inst_o),
      .fault_o(fault), .pvalid_o(pvalid_o), .ptaken_o(ptaken_o), .ptarget_o(ptarget_o),
      .hold_i(hold), .is_csr_i(is_csr), .commit_csr_i(commit_csr), .flush_i(flush),
      .wen_o(wen), .windex_o(windex), .wway_o(wway), .wtag_o(wtag), .wdata_o(wdata),
      .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(ar_addr),
      .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
      .io_master_arburst(arburst), .io_master_rvalid(rvalid), .io_master_rready(rready),
      .io_master_rdata(rdata), .io_master_rresp(rresp), .io_master_rlast(rlast),
      .io_master_rid(rid), .state_o(state)
   );

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic idle_inputs;
      valid_pre = 0; araddr = '0; hit = 0; hit_line = '0; pvalid = 0; ptaken = 0; ptarget = '0;
      ready_post = 1; hold = 0; is_csr = 0; commit_csr = 0; flush = 0;
      arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0; rid = '0;
   endtask

   task automatic accept(input logic [31:0] pc, input logic h, input logic [32*LW-1:0] line);
      valid_pre = 1; araddr = pc; hit = h; hit_line = line;
      tick;
      valid_pre = 0; hit = 0;
   endtask

   task automatic ar_handshake(input string name);
      int n = 0;
      while (!arvalid && n < 20) begin tick; n++; end
      checks++;
      if (arvalid !== 1'b1) begin
         errors++; $display("FAIL %s_ar_timeout: arvalid=%b required 1", name, arvalid);
      end
      arready = 1; tick; arready = 0;
   endtask

   task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
      rvalid = 1; rdata = d; rresp = resp; rlast = last;
      tick;
      rvalid = 0; rresp = '0; rlast = 0;
   endtask

   task automatic test_reset;
      idle_inputs; rst_n = 0;
      tick; tick;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", state); end
      checks++; if (ready_pre !== 1'b1) begin errors++; $display("FAIL reset_ready_pre: got %b required 1", ready_pre); end
      checks++; if ({arvalid, rready, valid_post, wen} !== 4'b0) begin
         errors++; $display("FAIL reset_outputs: arvalid/rready/valid_post/wen got %b required 0000", {arvalid, rready, valid_post, wen});
      end
      checks++; if ({pc_o, inst_o} !== 64'h0) begin errors++; $display("FAIL reset_pc_inst: got %h required 0", {pc_o, inst_o}); end
      rst_n = 1; tick;
   endtask

   task automatic test_hit;
      ready_post = 0; pvalid = 1; ptaken = 1; ptarget = 32'h8000_0100;
      accept(32'h8000_0008, 1, {32'hDEAD_0003, 32'h0010_0093, 32'hDEAD_0001, 32'hDEAD_0000});
      pvalid = 0; ptaken = 0; ptarget = '0;
      checks++; if (valid_post !== 1'b1) begin errors++; $display("FAIL hit_valid_post: got %b required 1", valid_post); end
      checks++; if (inst_o !== 32'h0010_0093) begin errors++; $display("FAIL hit_inst: got %h required 00100093", inst_o); end
      checks++; if (pc_o !== 32'h8000_0008) begin errors++; $display("FAIL hit_pc: got %h required 80000008", pc_o); end
      checks++; if ({pvalid_o, ptaken_o, ptarget_o} !== {2'b11, 32'h8000_0100}) begin
         errors++; $display("FAIL hit_prediction: got %b %b %h required 1 1 80000100", pvalid_o, ptaken_o, ptarget_o);
      end
      checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL hit_no_ar: got %b required 0", arvalid); end
      hold = 1; #1;
      checks++; if (valid_post !== 1'b0) begin errors++; $display("FAIL hit_hold: got %b required 0", valid_post); end
      hold = 0; ready_post = 1;
      tick;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL hit_return_idle: got %0d required 0", state); end
   endtask

   task automatic test_flush_hit;
      ready_post = 0;
      accept(32'h8000_0000, 1, {32'h4, 32'h3, 32'h2, 32'h1});
      flush = 1; ready_post = 1; #1;
      checks++; if (valid_post !== 1'b0) begin errors++; $display("FAIL flush_hit_valid: got %b required 0", valid_post); end
      tick; flush = 0;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL flush_hit_idle: got %0d required 0", state); end
   endtask

   task automatic test_miss_early;
      accept(32'h8000_0014, 0, '0);
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL miss_state_ar: got %0d required 1", state); end
      checks++; if (ar_addr !== 32'h8000_0010) begin errors++; $display("FAIL miss_araddr: got %h required 80000010", ar_addr); end
      checks++; if ({arid, arlen, arsize, arburst} !== {4'd0, 8'd3, 3'b010, 2'b01}) begin
         errors++; $display("FAIL miss_ar_fields: id %0d len %0d size %0d burst %0d required 0 3 2 1", arid, arlen, arsize, arburst);
      end
      tick;
      checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL miss_arvalid_hold: got %b required 1", arvalid); end
      ar_handshake("miss");
      checks++; if ({state, rready, arvalid} !== {3'd2, 2'b10}) begin
         errors++; $display("FAIL miss_state_r: state %0d rready %b arvalid %b required 2 1 0", state, rready, arvalid);
      end
      beat(32'hA000_0000, 2'b00, 0);
      checks++; if (valid_post !== 1'b0) begin errors++; $display("FAIL miss_no_fwd_beat0: got %b required 0", valid_post); end
      beat(32'hA000_0001, 2'b00, 0);
      checks++; if (valid_post !== 1'b1) begin errors++; $display("FAIL miss_fwd_beat1: got %b required 1", valid_post); end
      checks++; if (inst_o !== 32'hA000_0001) begin errors++; $display("FAIL miss_fwd_inst: got %h required a0000001", inst_o); end
      beat(32'hA000_0002, 2'b00, 0);
      checks++; if (valid_post !== 1'b0) begin errors++; $display("FAIL miss_single_delivery: got %b required 0", valid_post); end
      beat(32'hA000_0003, 2'b00, 1);
      checks++; if ({state, wen} !== {3'd3, 1'b1}) begin errors++; $display("FAIL miss_lwr: state %0d wen %b required 3 1", state, wen); end
      checks++; if ({windex, wtag} !== {3'd1, 25'h100_0000}) begin
         errors++; $display("FAIL miss_index_tag: got %h %h required 1 1000000", windex, wtag);
      end
      checks++; if (wdata !== {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000}) begin
         errors++; $display("FAIL miss_wdata: got %h", wdata);
      end
      tick;
      checks++; if ({state, wen} !== {3'd0, 1'b0}) begin errors++; $display("FAIL miss_idle: state %0d wen %b required 0 0", state, wen); end
   endtask

   task automatic test_flush_miss;
      accept(32'h8000_0024, 0, '0);
      ar_handshake("flush");
      flush = 1;
      beat(32'hB000_0000, 2'b00, 0);
      flush = 0;
      checks++; if ({state, rready, valid_post} !== {3'd7, 2'b10}) begin
         errors++; $display("FAIL flush_drain: state %0d rready %b valid %b required 7 1 0", state, rready, valid_post);
      end
      for (int i = 1; i < 4; i++) begin
         beat(32'hB000_0000 + 32'(i), 2'b00, i == 3);
         checks++; if (valid_post !== 1'b0) begin errors++; $display("FAIL flush_no_deliver_%0d: got %b required 0", i, valid_post); end
         if (i < 3) begin
            checks++; if (rready !== 1'b1) begin errors++; $display("FAIL flush_rready_%0d: got %b required 1", i, rready); end
         end
      end
      checks++; if ({state, wen, windex} !== {3'd3, 1'b1, 3'd2}) begin
         errors++; $display("FAIL flush_write: state %0d wen %b index %0d required 3 1 2", state, wen, windex);
      end
      tick;
      checks++; if ({state, valid_post} !== {3'd0, 1'b0}) begin
         errors++; $display("FAIL flush_idle: state %0d valid %b required 0 0", state, valid_post);
      end
   endtask

   task automatic test_bus_error;
      accept(32'h8000_000C, 0, '0);
      ar_handshake("err");
      beat(32'hC000_0000, 2'b00, 0);
      beat(32'hC000_0001, 2'b00, 0);
      beat(32'hC000_0002, 2'b10, 0);
      checks++; if (valid_post !== 1'b0) begin errors++; $display("FAIL err_no_early: got %b required 0", valid_post); end
      beat(32'hC000_0003, 2'b00, 1);
      checks++; if ({state, wen} !== {3'd3, 1'b0}) begin errors++; $display("FAIL err_no_wen: state %0d wen %b required 3 0", state, wen); end
      tick;
      checks++; if ({state, valid_post, fault} !== {3'd5, 2'b11}) begin
         errors++; $display("FAIL err_deliver: state %0d valid %b fault %b required 5 1 1", state, valid_post, fault);
      end
      checks++; if (inst_o !== 32'hC000_0003) begin errors++; $display("FAIL err_inst: got %h required c0000003", inst_o); end
      tick;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL err_idle: got %0d required 0", state); end
   endtask

   task automatic test_csr;
      ready_post = 0;
      accept(32'h8000_0004, 1, {32'h0, 32'h0, 32'h3000_2573, 32'h0});
      is_csr = 1; ready_post = 1;
      tick; is_csr = 0;
      checks++; if ({state, ready_pre} !== {3'd6, 1'b0}) begin
         errors++; $display("FAIL csr_wait: state %0d ready_pre %b required 6 0", state, ready_pre);
      end
      flush = 1; valid_pre = 1; hit = 1; araddr = 32'h8000_0040;
      tick; flush = 0; valid_pre = 0; hit = 0;
      checks++; if ({state, ready_pre} !== {3'd6, 1'b0}) begin
         errors++; $display("FAIL csr_holds: state %0d ready_pre %b required 6 0", state, ready_pre);
      end
      commit_csr = 1; tick; commit_csr = 0;
      checks++; if ({state, ready_pre} !== {3'd0, 1'b1}) begin
         errors++; $display("FAIL csr_commit: state %0d ready_pre %b required 0 1", state, ready_pre);
      end
      ready_post = 0;
      accept(32'h8000_0000, 1, {32'h0, 32'h0, 32'h0, 32'h0000_0013});
      checks++; if ({state, inst_o} !== {3'd4, 32'h0000_0013}) begin
         errors++; $display("FAIL csr_next_accept: state %0d inst %h required 4 00000013", state, inst_o);
      end
      ready_post = 1; tick;
   endtask

   task automatic test_lfsr_ways;
      logic [2:0] exp_way [3];
      exp_way[0] = 3'd0; exp_way[1] = 3'd0; exp_way[2] = 3'd4;
      idle_inputs; rst_n = 0; tick; rst_n = 1; tick;
      for (int k = 0; k < 3; k++) begin
         accept(32'h8000_0100 + 32'(k * 16), 0, '0);
         ar_handshake("lfsr");
         for (int b = 0; b < 4; b++) beat(32'hD000_0000 + 32'(b), 2'b00, b == 3);
         checks++; if ({state, wen, wway} !== {3'd3, 1'b1, exp_way[k]}) begin
            errors++; $display("FAIL lfsr_way_%0d: state %0d wen %b way %0d required 3 1 %0d", k, state, wen, wway, exp_way[k]);
         end
         tick;
         checks++; if (state !== 3'd0) begin errors++; $display("FAIL lfsr_idle_%0d: got %0d required 0", k, state); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs;
      test_reset;
      test_hit;
      test_flush_hit;
      test_miss_early;
      test_flush_miss;
      test_bus_error;
      test_csr;
      test_lfsr_ways;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
